// File: rtl/cbx_pkg.sv
// Shared types and helpers for the X-channel connection block.
// Pure declarations: no logic, no latency, no flow control.
package cbx_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } cfg_state_e;

    function automatic int sel_width(input int mux_size);
        return $clog2(mux_size + 1);
    endfunction

    // Inputs come in left/right pairs; each pair steps TRACK_STEP tracks further round the channel.
    function automatic int track_of(input int pin, input int k, input int step, input int chan_w);
        return (pin + (k / 2) * step) % chan_w;
    endfunction

endpackage

// File: rtl/cbx_pin_mux.sv
// One grid pin: binary-select decode and mux; select 0 or out of range drives 0.
// Purely combinational, no flow control.
module cbx_pin_mux #(
    parameter int MUX_SIZE = 6,
    parameter int SEL_W    = 3
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    input  logic [MUX_SIZE-1:0] mux_in,
    output logic                pin
);

    always_comb begin
        pin = 1'b0;
        if (en) begin
            for (int k = 0; k < MUX_SIZE; k++) begin
                if (sel == SEL_W'(k + 1)) begin
                    pin = mux_in[k];
                end
            end
        end
    end

endmodule

// File: rtl/cbx_param_ccff.sv
// X-channel connection block with a double-buffered serial config chain; commit has one-edge latency.
// No backpressure; CBX_CFG_PARITY_EN adds an even-parity MSB to the chain and the cfg_par_ok port.
module cbx_param_ccff
    import cbx_pkg::*;
#(
    parameter int CHAN_W     = 9,
    parameter int NUM_PINS   = 11,
    parameter int MUX_SIZE   = 6,
    parameter int TRACK_STEP = 4
) (
    input  logic                prog_clk,
    input  logic                pReset_n,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_PINS-1:0] grid_pin,
    input  logic                cfg_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    input  logic                cfg_commit,
    output logic                cfg_full,
    output logic                cfg_valid,
    output logic                cfg_err
`ifdef CBX_CFG_PARITY_EN
    ,
    output logic                cfg_par_ok
`endif
);

    localparam int SEL_W    = sel_width(MUX_SIZE);
    localparam int CFG_BITS = NUM_PINS * SEL_W;
`ifdef CBX_CFG_PARITY_EN
    localparam int CHAIN_LEN = CFG_BITS + 1;
`else
    localparam int CHAIN_LEN = CFG_BITS;
`endif
    localparam int              CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0] chain_q;
    logic [CFG_BITS-1:0]  active_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_base;
    cfg_state_e           state_q, state_d;
    logic                 valid_q, err_q;
    logic                 accept, reject, par_good, clear_cnt;

`ifdef CBX_CFG_PARITY_EN
    logic par_ok_q;
    assign par_good   = ~(^chain_q);
    assign cfg_par_ok = par_ok_q;
`else
    assign par_good = 1'b1;
`endif

    always_comb begin
        accept    = 1'b0;
        reject    = 1'b0;
        cnt_base  = cnt_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        if (cfg_commit) begin
            if (state_q == FULL && par_good) begin
                accept = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end
        // A full chain is consumed by any commit; only a parity failure can reject one.
        clear_cnt = accept | (reject & (state_q == FULL));
        if (clear_cnt) begin
            cnt_base = '0;
        end
        cnt_d = cnt_base;
        if (cfg_en && cnt_base != CNT_MAX) begin
            cnt_d = cnt_base + 1'b1;
        end
        if (cnt_d == '0) begin
            state_d = EMPTY;
        end else if (cnt_d == CNT_MAX) begin
            state_d = FULL;
        end else begin
            state_d = LOADING;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            chain_q  <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef CBX_CFG_PARITY_EN
            par_ok_q <= 1'b0;
`endif
        end else begin
            if (cfg_en) begin
                chain_q <= {chain_q[CHAIN_LEN-2:0], ccff_head};
            end
            if (accept) begin
                active_q <= chain_q[CFG_BITS-1:0];
                valid_q  <= 1'b1;
`ifdef CBX_CFG_PARITY_EN
                par_ok_q <= 1'b1;
`endif
            end
            err_q <= reject;
        end
    end

    assign ccff_tail       = chain_q[CHAIN_LEN-1];
    assign cfg_full        = (state_q == FULL);
    assign cfg_valid       = valid_q;
    assign cfg_err         = err_q;
    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [MUX_SIZE-1:0] mux_in;
        for (genvar k = 0; k < MUX_SIZE; k++) begin : g_in
            localparam int T = track_of(p, k, TRACK_STEP, CHAN_W);
            if (k % 2 == 0) begin : g_left
                assign mux_in[k] = chanx_left_in[T];
            end else begin : g_right
                assign mux_in[k] = chanx_right_in[T];
            end
        end
        cbx_pin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .sel    (active_q[p*SEL_W +: SEL_W]),
            .en     (valid_q),
            .mux_in (mux_in),
            .pin    (grid_pin[p])
        );
    end

endmodule

// File: tb/tb_cbx_param_ccff.sv
// Bench for cbx_param_ccff: hand table, random traffic against a bit-history model, corner sequences.
module tb_cbx_param_ccff;

    localparam int CHAN_W = 9;
    localparam int NP     = 11;
    localparam int MS     = 6;
    localparam int STEP   = 4;
    localparam int SW     = $clog2(MS + 1);
    localparam int CFG    = NP * SW;
`ifdef CBX_CFG_PARITY_EN
    localparam int CHAIN = CFG + 1;
`else
    localparam int CHAIN = CFG;
`endif

    logic              prog_clk = 1'b0;
    logic              pReset_n;
    logic [CHAN_W-1:0] left_in, right_in, left_out, right_out;
    logic [NP-1:0]     grid;
    logic              cfg_en, ccff_head, ccff_tail, cfg_commit;
    logic              cfg_full, cfg_valid, cfg_err;
`ifdef CBX_CFG_PARITY_EN
    logic              par_ok;
`endif

    cbx_param_ccff dut (
        .prog_clk        (prog_clk),
        .pReset_n        (pReset_n),
        .chanx_left_in   (left_in),
        .chanx_right_in  (right_in),
        .chanx_left_out  (left_out),
        .chanx_right_out (right_out),
        .grid_pin        (grid),
        .cfg_en          (cfg_en),
        .ccff_head       (ccff_head),
        .ccff_tail       (ccff_tail),
        .cfg_commit      (cfg_commit),
        .cfg_full        (cfg_full),
        .cfg_valid       (cfg_valid),
        .cfg_err         (cfg_err)
`ifdef CBX_CFG_PARITY_EN
        ,
        .cfg_par_ok      (par_ok)
`endif
    );

    always #5 prog_clk = ~prog_clk;

    // Reference model: every bit shifted since reset, newest last.
    bit  hist[$];
    int  m_cnt;
    bit  m_valid, m_err, m_par;
    int  m_sel[NP];
    int  n_vec = 0;
    int  n_bad = 0;

    typedef struct {
        int                pin;
        int                sel;
        logic [CHAN_W-1:0] l;
        logic [CHAN_W-1:0] r;
        logic              exp;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit chain_bit(input int j);
        if (j < hist.size()) return hist[hist.size() - 1 - j];
        return 1'b0;
    endfunction

    function automatic bit parity_ok();
`ifdef CBX_CFG_PARITY_EN
        bit x = 1'b0;
        for (int j = 0; j < CHAIN; j++) x ^= chain_bit(j);
        return x == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic exp_pin(input int p);
        int s, k, t;
        s = m_sel[p];
        if (!m_valid || s < 1 || s > MS) return 1'b0;
        k = s - 1;
        t = (p + (k / 2) * STEP) % CHAN_W;
        return (k % 2 == 0) ? left_in[t] : right_in[t];
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cnt = 0; m_valid = 0; m_err = 0; m_par = 0;
        for (int p = 0; p < NP; p++) m_sel[p] = 0;
    endtask

    task automatic model_clk(input bit en, input bit h, input bit c);
        bit ok = 1'b0;
        m_err = 1'b0;
        if (c) begin
            if (m_cnt == CHAIN && parity_ok()) ok = 1'b1;
            else m_err = 1'b1;
            if (m_cnt == CHAIN) m_cnt = 0;
            if (ok) begin
                for (int p = 0; p < NP; p++) begin
                    m_sel[p] = 0;
                    for (int b = 0; b < SW; b++) m_sel[p] |= int'(chain_bit(p * SW + b)) << b;
                end
                m_valid = 1'b1;
                m_par   = 1'b1;
            end
        end
        if (en) begin
            hist.push_back(h);
            if (hist.size() > CHAIN) void'(hist.pop_front());
            if (m_cnt < CHAIN) m_cnt++;
        end
    endtask

    task automatic check_all(input string tag);
        logic [NP-1:0] eg;
        for (int p = 0; p < NP; p++) eg[p] = exp_pin(p);
        chk({tag, " grid"}, 64'(grid), 64'(eg));
        chk({tag, " tail"}, 64'(ccff_tail), 64'(chain_bit(CHAIN - 1)));
        chk({tag, " full"}, 64'(cfg_full), 64'(m_cnt == CHAIN));
        chk({tag, " valid"}, 64'(cfg_valid), 64'(m_valid));
        chk({tag, " err"}, 64'(cfg_err), 64'(m_err));
        chk({tag, " pass"}, 64'({left_out, right_out}), 64'({right_in, left_in}));
`ifdef CBX_CFG_PARITY_EN
        chk({tag, " par_ok"}, 64'(par_ok), 64'(m_par));
`endif
    endtask

    task automatic cyc(input bit en, input bit h, input bit c);
        cfg_en = en; ccff_head = h; cfg_commit = c;
        @(posedge prog_clk);
        model_clk(en, h, c);
        #1;
        cfg_en = 1'b0; cfg_commit = 1'b0;
        check_all("cyc");
    endtask

    function automatic logic [CFG-1:0] mk_cfg(input int pin, input int sel);
        logic [CFG-1:0] v;
        for (int p = 0; p < NP; p++) v[p*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
        if (pin >= 0) v[pin*SW +: SW] = SW'(sel);
        return v;
    endfunction

    task automatic load_cfg(input logic [CFG-1:0] v, input bit bad);
`ifdef CBX_CFG_PARITY_EN
        cyc(1'b1, (^v) ^ bad, 1'b0);
`else
        if (bad) $display("note: parity corruption requested without parity build");
`endif
        for (int i = CFG - 1; i >= 0; i--) cyc(1'b1, v[i], 1'b0);
    endtask

    initial begin
        logic [CFG-1:0] v;
        bit             b[50];
        int             idx, pre;

        tbl[0] = '{0, 1, 9'h1FF, 9'h000, 1'b1};
        tbl[1] = '{0, 1, 9'h1FE, 9'h1FF, 1'b0};
        tbl[2] = '{2, 6, 9'h1FF, 9'h002, 1'b1};
        tbl[3] = '{2, 6, 9'h1FF, 9'h1FD, 1'b0};
        tbl[4] = '{2, 7, 9'h1FF, 9'h1FF, 1'b0};
        tbl[5] = '{2, 0, 9'h1FF, 9'h1FF, 1'b0};
        tbl[6] = '{1, 2, 9'h000, 9'h002, 1'b1};
        tbl[7] = '{1, 3, 9'h020, 9'h000, 1'b1};
        tbl[8] = '{10, 5, 9'h001, 9'h000, 1'b1};
        tbl[9] = '{10, 4, 9'h1FF, 9'h1DF, 1'b0};

        model_reset();
        pReset_n = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0; cfg_commit = 1'b0;
        left_in = '1; right_in = '1;
        #12;
        chk("reset grid", 64'(grid), 64'(0));
        chk("reset valid", 64'(cfg_valid), 64'(0));
        chk("reset tail", 64'(ccff_tail), 64'(0));
        chk("reset full", 64'(cfg_full), 64'(0));
        chk("reset err", 64'(cfg_err), 64'(0));
        chk("reset pass", 64'({left_out, right_out}), 64'({CHAN_W'('1), CHAN_W'('1)}));
        #10;
        pReset_n = 1'b1;

        // Table: one pin's select against hand-derived pin values.
        for (int i = 0; i < 10; i++) begin
            load_cfg(mk_cfg(tbl[i].pin, tbl[i].sel), 1'b0);
            cyc(1'b0, 1'b0, 1'b1);
            chk("tbl valid", 64'(cfg_valid), 64'(1));
            chk("tbl full", 64'(cfg_full), 64'(0));
            left_in = tbl[i].l; right_in = tbl[i].r;
            #1;
            chk($sformatf("tbl%0d pin", i), 64'(grid[tbl[i].pin]), 64'(tbl[i].exp));
            check_all("tbl");
        end

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            left_in  = CHAN_W'($urandom);
            right_in = CHAN_W'($urandom);
            cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0);
        end

        // Partial load then commit: rejected, old config stays.
        load_cfg(mk_cfg(-1, 0), 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'($urandom), 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("partial err", 64'(cfg_err), 64'(1));
        chk("partial valid", 64'(cfg_valid), 64'(1));
        cyc(1'b0, 1'b0, 1'b0);
        chk("partial err pulse", 64'(cfg_err), 64'(0));

        // Over-long load: oldest bits leave through the tail in order.
        v   = mk_cfg(-1, 0);
        pre = 50 - CHAIN;
        idx = 0;
        for (int i = 0; i < pre; i++) b[idx++] = 1'($urandom);
`ifdef CBX_CFG_PARITY_EN
        b[idx++] = ^v;
`endif
        for (int i = CFG - 1; i >= 0; i--) b[idx++] = v[i];
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, b[i], 1'b0);
            if (i >= CHAIN - 1 && i <= CHAIN + 4)
                chk($sformatf("tail bit%0d", i - CHAIN + 1), 64'(ccff_tail), 64'(b[i - CHAIN + 1]));
        end
        chk("long full", 64'(cfg_full), 64'(1));
        cyc(1'b1, 1'b1, 1'b1);
        chk("commit+en valid", 64'(cfg_valid), 64'(1));
        chk("commit+en err", 64'(cfg_err), 64'(0));
        chk("commit+en full", 64'(cfg_full), 64'(0));
        for (int i = 0; i < CHAIN - 2; i++) cyc(1'b1, 1'($urandom), 1'b0);
        chk("cnt one short", 64'(cfg_full), 64'(0));
        cyc(1'b1, 1'($urandom), 1'b0);
        chk("cnt reaches full", 64'(cfg_full), 64'(1));
        cyc(1'b0, 1'b0, 1'b1);

        // Reset in the middle of shift 30.
        for (int i = 0; i < 29; i++) cyc(1'b1, 1'b1, 1'b0);
        cfg_en = 1'b1; ccff_head = 1'b1;
        #2;
        pReset_n = 1'b0;
        #1;
        model_reset();
        chk("mid-reset grid", 64'(grid), 64'(0));
        chk("mid-reset valid", 64'(cfg_valid), 64'(0));
        chk("mid-reset tail", 64'(ccff_tail), 64'(0));
        chk("mid-reset full", 64'(cfg_full), 64'(0));
        @(posedge prog_clk);
        #3;
        cfg_en = 1'b0;
        pReset_n = 1'b1;
        check_all("post-reset");
        v = mk_cfg(0, 1);
`ifdef CBX_CFG_PARITY_EN
        cyc(1'b1, ^v, 1'b0);
`endif
        for (int i = CFG - 1; i >= 1; i--) cyc(1'b1, v[i], 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("short after reset err", 64'(cfg_err), 64'(1));
        chk("short after reset valid", 64'(cfg_valid), 64'(0));
        cyc(1'b1, v[0], 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("fresh load valid", 64'(cfg_valid), 64'(1));

`ifdef CBX_CFG_PARITY_EN
        load_cfg(mk_cfg(-1, 0), 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("bad parity err", 64'(cfg_err), 64'(1));
        chk("bad parity full cleared", 64'(cfg_full), 64'(0));
        chk("bad parity valid kept", 64'(cfg_valid), 64'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
